// File: rtl/wb_hyper_arb.sv
// Two-master Wishbone arbiter in front of a HyperRAM controller data port.
// Holds each grant for a whole cycle, inserts one idle cycle between grants, and has an ack watchdog.
module wb_hyper_arb #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [aw-1:0]   m0_adr_i,
    input  logic [dw-1:0]   m0_dat_i,
    input  logic [dw/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    output logic [dw-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [aw-1:0]   m1_adr_i,
    input  logic [dw-1:0]   m1_dat_i,
    input  logic [dw/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    output logic [dw-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [aw-1:0]   s_adr_o,
    output logic [dw-1:0]   s_dat_o,
    output logic [dw/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    input  logic [dw-1:0]   s_dat_i,
    input  logic            s_ack_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, RELEASE} state_t;

    state_t        r_state, w_state_next;
    logic          r_last, w_last_next;
    logic [CW-1:0] r_wdog, w_wdog_next;

    logic [aw-1:0]   w_adr [2];
    logic [dw-1:0]   w_wdat [2];
    logic [dw/8-1:0] w_sel [2];
    logic [2:0]      w_cti [2];
    logic            w_we [2];
    logic            w_cyc [2];
    logic            w_stb [2];
    logic [dw-1:0]   w_rdat [2];
    logic            w_ack [2];
    logic            w_err [2];

    assign w_adr[0]  = m0_adr_i;  assign w_adr[1]  = m1_adr_i;
    assign w_wdat[0] = m0_dat_i;  assign w_wdat[1] = m1_dat_i;
    assign w_sel[0]  = m0_sel_i;  assign w_sel[1]  = m1_sel_i;
    assign w_cti[0]  = m0_cti_i;  assign w_cti[1]  = m1_cti_i;
    assign w_we[0]   = m0_we_i;   assign w_we[1]   = m1_we_i;
    assign w_cyc[0]  = m0_cyc_i;  assign w_cyc[1]  = m1_cyc_i;
    assign w_stb[0]  = m0_stb_i;  assign w_stb[1]  = m1_stb_i;

    logic w_gnt_valid, w_gnt_idx, w_g_cyc, w_g_stb, w_timeout;

    assign w_gnt_valid = (r_state == GNT0) || (r_state == GNT1);
    assign w_gnt_idx   = (r_state == GNT1);
    assign w_g_cyc     = w_gnt_valid & w_cyc[w_gnt_idx];
    assign w_g_stb     = w_g_cyc & w_stb[w_gnt_idx];
    // An ack in the final wait cycle suppresses the timeout; reset never reports one.
    assign w_timeout   = w_g_stb & ~s_ack_i & ~wb_rst_i & (r_wdog == CW'(TIMEOUT - 1));

    assign s_cyc_o = w_g_cyc & ~w_timeout;
    assign s_stb_o = w_g_stb & ~w_timeout;
    assign s_adr_o = w_gnt_valid ? w_adr[w_gnt_idx]  : '0;
    assign s_dat_o = w_gnt_valid ? w_wdat[w_gnt_idx] : '0;
    assign s_sel_o = w_gnt_valid ? w_sel[w_gnt_idx]  : '0;
    assign s_cti_o = w_gnt_valid ? w_cti[w_gnt_idx]  : 3'b000;
    assign s_we_o  = w_gnt_valid & w_we[w_gnt_idx];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            logic w_mine;
            assign w_mine     = w_gnt_valid && (w_gnt_idx == 1'(gi));
            assign w_rdat[gi] = w_mine ? s_dat_i : '0;
            assign w_ack[gi]  = w_mine & s_ack_i;
            assign w_err[gi]  = w_mine & w_timeout;
        end
    endgenerate

    assign m0_dat_o = w_rdat[0];  assign m1_dat_o = w_rdat[1];
    assign m0_ack_o = w_ack[0];   assign m1_ack_o = w_ack[1];
    assign m0_err_o = w_err[0];   assign m1_err_o = w_err[1];

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                // r_last high means m1 was served last, so m0 takes a tie.
                if (m0_cyc_i && m1_cyc_i) w_state_next = r_last ? GNT0 : GNT1;
                else if (m0_cyc_i)        w_state_next = GNT0;
                else if (m1_cyc_i)        w_state_next = GNT1;
            end
            GNT0, GNT1: begin
                if (!w_g_cyc || w_timeout) begin
                    w_state_next = RELEASE;
                    w_last_next  = w_gnt_idx;
                end
            end
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_wdog_next = '0;
        if (w_g_stb && !s_ack_i && !w_timeout) w_wdog_next = r_wdog + CW'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_wdog  <= w_wdog_next;
        end
    end
endmodule

// File: doc/wb_hyper_arb.md
WB_HYPER_ARB -- requirements
Module: wb_hyper_arb

Interface
REQ-001 Parameter: dw, 32, Wishbone data width.
REQ-002 Parameter: aw, 32, Wishbone address width.
REQ-003 Parameter: TIMEOUT, 1024, max cycles granted stb may wait for slave ack (>=2).
REQ-004 Port: wb_clk_i  input  1  single clock for the whole block.
REQ-005 Port: wb_rst_i  input  1  reset, synchronous and active-high.
REQ-006 Ports: m0_adr_i/m1_adr_i  input  aw  master 0/1 address.
REQ-007 Ports: m0_dat_i/m1_dat_i  input  dw  master 0/1 write data.
REQ-008 Ports: m0_sel_i/m1_sel_i  input  dw/8  byte selects.
REQ-009 Ports: m0_we_i/m1_we_i, m0_cyc_i/m1_cyc_i, m0_stb_i/m1_stb_i  input  1 each  write enable, cycle, strobe.
REQ-010 Ports: m0_cti_i/m1_cti_i  input  3  cycle type (000 classic, 010 incrementing, 111 end).
REQ-011 Ports: m0_dat_o/m1_dat_o  output  dw  read data.
REQ-012 Ports: m0_ack_o/m1_ack_o, m0_err_o/m1_err_o  output  1 each  acknowledge, timeout error.
REQ-013 Ports: s_adr_o aw, s_dat_o dw, s_sel_o dw/8, s_we_o 1, s_cyc_o 1, s_stb_o 1, s_cti_o 3  output  to hyperram controller data slave.
REQ-014 Ports: s_dat_i dw, s_ack_i 1  input  from hyperram controller.

Function
REQ-015 FSM states SHALL be IDLE, GNT0, GNT1, RELEASE; state and grant registered.
REQ-016 IDLE: if exactly one mN_cyc_i high, next state GNTN; if both high, grant the master not served last (last-served flag resets to 1, so m0 wins first tie).
REQ-017 Grant latency SHALL be one cycle: slave sees s_cyc_o the cycle after IDLE samples the request.
REQ-018 In GNTN, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cti_o/s_cyc_o/s_stb_o SHALL combinationally follow master N; mN_dat_o=s_dat_i, mN_ack_o=s_ack_i.
REQ-019 The non-granted master SHALL see ack=0, err=0, dat_o=0 regardless of slave activity.
REQ-020 In IDLE and RELEASE, s_cyc_o=s_stb_o=s_we_o=0, s_cti_o=000, s_adr_o/s_dat_o/s_sel_o=0.
REQ-021 Grant SHALL be held for the whole cycle (including incrementing bursts) until granted mN_cyc_i samples low; then GNTN -> RELEASE, last-served flag := N.
REQ-022 RELEASE SHALL last exactly one cycle then go to IDLE, guaranteeing >=1 cycle of s_cyc_o low between any two transactions (hyperram CS deassert).
REQ-023 Watchdog: counter (ceil(log2(TIMEOUT+1)) bits) clears on any cycle with s_ack_i high or granted stb low, increments while granted stb high and s_ack_i low.
REQ-024 When counter reaches TIMEOUT, mN_err_o SHALL pulse high for one cycle, s_cyc_o/s_stb_o forced low that same cycle, state -> RELEASE, counter cleared; a late s_ack_i SHALL not be forwarded.
REQ-025 Ack and timeout in the same cycle: ack wins, err not asserted, counter cleared.
REQ-026 Master dropping cyc mid-burst SHALL end the grant per REQ-021; no further slave strobes issued.
REQ-027 A request from the other master during GNTN SHALL not pre-empt; it is served after RELEASE/IDLE.

Reset
REQ-028 On wb_rst_i high at a clock edge: state=IDLE, last-served flag=1, watchdog=0.
REQ-029 During and after reset all outputs SHALL be 0 (per REQ-019/020) until a new grant; reset mid-transaction SHALL drop s_cyc_o on the next edge without error pulse.

Verification
REQ-030 Single write: m0 writes 0x12345678 to 0x0 classic -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o mirrors s_ack_i, m1 sees nothing.
REQ-031 Simultaneous request after reset: m0,m1 both cyc in same cycle -> GNT0 first, then RELEASE, IDLE, GNT1; next tie goes to m0 only if m1 was last served.
REQ-032 Burst hold: m1 4-beat incrementing read (cti 010,010,010,111) from 0x0 while m0 requests -> all 4 beats to m1, m0 granted only after m1 cyc low plus one RELEASE cycle.
REQ-033 Timeout: TIMEOUT=8, slave never acks m0 read -> m0_err_o single pulse on 8th wait cycle, s_cyc_o low same cycle, m1 then granted normally.
REQ-034 Reset mid-burst: wb_rst_i asserted on beat 2 of m0 write burst -> s_cyc_o low next edge, no err, state IDLE, m0 wins next tie.
